// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with valid/ready handshake, flush-to-bubble and stall counter.
// Optional SKID_BUF_EN adds a one-entry skid buffer and a registered in_ready.
module pipe_stage_reg #(
    parameter int PC_W     = 32,
    parameter int OP_W     = 14,
    parameter int DATA_W   = 32,
    parameter int NUM_DATA = 3,
    parameter int CTRL_W   = 6,
    parameter int IDX_W    = 5,
    parameter int CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PC_W-1:0]            in_pc,
    input  logic [OP_W-1:0]            in_opcode,
    input  logic [NUM_DATA*DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [IDX_W-1:0]           in_rd_idx,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            out_pc,
    output logic [OP_W-1:0]            out_opcode,
    output logic [NUM_DATA*DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [IDX_W-1:0]           out_rd_idx,
    output logic [CNT_W-1:0]           stall_cnt
);

    localparam int PAY_W = PC_W + OP_W + NUM_DATA * DATA_W + IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PAY_W-1:0]  w_in_pay;
    logic              w_accept;
    logic              w_stall;
    logic              r_out_valid;
    logic [PAY_W-1:0]  r_out_pay;
    logic [CTRL_W-1:0] r_out_ctrl;
    logic [CNT_W-1:0]  r_stall_cnt;

    assign w_in_pay = {in_pc, in_opcode, in_data, in_rd_idx};
    assign w_accept = in_valid && in_ready;
    assign w_stall  = r_out_valid && !out_ready;

`ifdef SKID_BUF_EN
    logic              r_sk_valid;
    logic [PAY_W-1:0]  r_sk_pay;
    logic [CTRL_W-1:0] r_sk_ctrl;
    logic              w_out_free;

    assign w_out_free = !r_out_valid || out_ready;
    assign in_ready   = !r_sk_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_pay   <= '0;
            r_out_ctrl  <= '0;
            r_sk_valid  <= 1'b0;
            r_sk_pay    <= '0;
            r_sk_ctrl   <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_out_ctrl  <= '0;
            r_sk_valid  <= 1'b0;
            r_sk_ctrl   <= '0;
        end else if (w_out_free) begin
            // skid holds the older entry, so it drains first
            if (r_sk_valid) begin
                r_out_valid <= 1'b1;
                r_out_pay   <= r_sk_pay;
                r_out_ctrl  <= r_sk_ctrl;
                r_sk_valid  <= 1'b0;
                r_sk_ctrl   <= '0;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_pay   <= w_in_pay;
                r_out_ctrl  <= in_ctrl;
            end else begin
                r_out_valid <= 1'b0;
                r_out_ctrl  <= '0;
            end
        end else if (w_accept) begin
            r_sk_valid <= 1'b1;
            r_sk_pay   <= w_in_pay;
            r_sk_ctrl  <= in_ctrl;
        end
    end
`else
    logic w_consume;

    assign w_consume = r_out_valid && out_ready;
    assign in_ready  = !r_out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_pay   <= '0;
            r_out_ctrl  <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_out_ctrl  <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_pay   <= w_in_pay;
            r_out_ctrl  <= in_ctrl;
        end else if (w_consume) begin
            r_out_valid <= 1'b0;
            r_out_ctrl  <= '0;
        end
    end
`endif

    // flush deliberately leaves the counter alone
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_ctrl  = r_out_ctrl;
    assign stall_cnt = r_stall_cnt;
    assign {out_pc, out_opcode, out_data, out_rd_idx} = r_out_pay;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: vector table plus scoreboard of accepted instructions.
// Stall counter is built 4 bits wide so saturation is reachable quickly.
module tb_pipe_stage_reg;

    localparam int PC_W = 32, OP_W = 14, DATA_W = 32, ND = 3;
    localparam int CTRL_W = 6, IDX_W = 5, CNT_W = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [PC_W-1:0] in_pc = '0;
    logic [OP_W-1:0] in_opcode = '0;
    logic [ND*DATA_W-1:0] in_data = '0;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic [IDX_W-1:0] in_rd_idx = '0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic [PC_W-1:0] out_pc;
    logic [OP_W-1:0] out_opcode;
    logic [ND*DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [IDX_W-1:0] out_rd_idx;
    logic [CNT_W-1:0] stall_cnt;

    pipe_stage_reg #(
        .PC_W(PC_W), .OP_W(OP_W), .DATA_W(DATA_W), .NUM_DATA(ND),
        .CTRL_W(CTRL_W), .IDX_W(IDX_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_opcode(in_opcode), .in_data(in_data),
        .in_ctrl(in_ctrl), .in_rd_idx(in_rd_idx),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_opcode(out_opcode), .out_data(out_data),
        .out_ctrl(out_ctrl), .out_rd_idx(out_rd_idx),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic [OP_W-1:0] op;
        logic [ND*DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
        logic [IDX_W-1:0] rd;
    } item_t;

    typedef struct {
        logic vld, ordy, fl;
        logic [PC_W-1:0] pc;
        logic [OP_W-1:0] op;
        logic [CTRL_W-1:0] ctrl;
        logic rdy, ov;
        logic [PC_W-1:0] epc;
        logic [CTRL_W-1:0] ectrl;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    item_t q[$];
    vec_t vecs[$];
    int n_chk = 0;
    int n_fail = 0;
    logic [CNT_W-1:0] m_cnt = '0;

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [ND*DATA_W-1:0] mk_data(input logic [PC_W-1:0] pc);
        return {pc ^ 32'hA5A5_5A5A, pc + 32'd1, ~pc};
    endfunction

    task automatic drive(input logic v, input logic r, input logic f,
                         input logic [PC_W-1:0] pc, input logic [OP_W-1:0] op,
                         input logic [CTRL_W-1:0] c);
        in_valid  = v;
        out_ready = r;
        flush     = f;
        in_pc     = pc;
        in_opcode = op;
        in_ctrl   = c;
        in_data   = mk_data(pc);
        in_rd_idx = pc[6:2];
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // reference model: queue of instructions held in the stage, head at the output
    initial begin
        forever begin
            item_t it;
            @(negedge clk);
            if (reset) begin
                q.delete();
                m_cnt = '0;
            end else begin
                check("valid", out_valid, q.size() != 0);
                if (!out_valid) check("bubble_ctrl", out_ctrl, '0);
                check("stall_cnt", stall_cnt, m_cnt);
                if (q.size() != 0) begin
                    check("sb_pc", out_pc, q[0].pc);
                    check("sb_op", out_opcode, q[0].op);
                    check("sb_data", out_data, q[0].data);
                    check("sb_ctrl", out_ctrl, q[0].ctrl);
                    check("sb_rd", out_rd_idx, q[0].rd);
                    if (!out_ready && m_cnt != 4'hF) m_cnt = m_cnt + 1'b1;
                    if (out_ready) void'(q.pop_front());
                end
                if (flush) begin
                    q.delete();
                end else if (in_valid && in_ready) begin
                    it.pc = in_pc; it.op = in_opcode; it.data = in_data;
                    it.ctrl = in_ctrl; it.rd = in_rd_idx;
                    q.push_back(it);
                end
            end
        end
    end

    initial begin
        //               vld ordy fl  pc        op       ctrl  rdy ov epc       ectrl cnt
        vecs.push_back('{1, 1, 0, 32'h100, 14'h001, 6'h01, 1, 1, 32'h100, 6'h01, 4'd0});
        vecs.push_back('{1, 1, 0, 32'h104, 14'h002, 6'h02, 1, 1, 32'h104, 6'h02, 4'd0});
        vecs.push_back('{1, 1, 0, 32'h108, 14'h003, 6'h04, 1, 1, 32'h108, 6'h04, 4'd0});
        vecs.push_back('{1, 1, 0, 32'h10C, 14'h0A5, 6'h09, 1, 1, 32'h10C, 6'h09, 4'd0});
        vecs.push_back('{0, 0, 0, 32'h0,   14'h0,   6'h00, 0, 1, 32'h10C, 6'h09, 4'd1});
        vecs.push_back('{0, 0, 0, 32'h0,   14'h0,   6'h00, 0, 1, 32'h10C, 6'h09, 4'd2});
        vecs.push_back('{0, 0, 0, 32'h0,   14'h0,   6'h00, 0, 1, 32'h10C, 6'h09, 4'd3});
        vecs.push_back('{0, 0, 0, 32'h0,   14'h0,   6'h00, 0, 1, 32'h10C, 6'h09, 4'd4});
        vecs.push_back('{0, 1, 0, 32'h0,   14'h0,   6'h00, 1, 0, 32'h0,   6'h00, 4'd4});
        vecs.push_back('{0, 1, 0, 32'h0,   14'h0,   6'h00, 1, 0, 32'h0,   6'h00, 4'd4});
        vecs.push_back('{1, 0, 0, 32'h200, 14'h011, 6'h08, 1, 1, 32'h200, 6'h08, 4'd4});
        vecs.push_back('{1, 1, 1, 32'h204, 14'h012, 6'h01, 1, 0, 32'h0,   6'h00, 4'd4});
        vecs.push_back('{0, 1, 0, 32'h0,   14'h0,   6'h00, 1, 0, 32'h0,   6'h00, 4'd4});

        // reset dominates a valid input with all ctrl bits set
        drive(1, 1, 0, 32'hDEAD_BEEF, 14'h3FFF, 6'h3F);
        reset = 1'b1;
        repeat (2) cyc();
        check("rst_valid", out_valid, 1'b0);
        check("rst_ctrl", out_ctrl, 6'h00);
        check("rst_cnt", stall_cnt, 4'd0);
        check("rst_pc", out_pc, 32'h0);
        drive(0, 1, 0, 32'h0, 14'h0, 6'h00);
        reset = 1'b0;
        cyc();

        foreach (vecs[i]) begin
            drive(vecs[i].vld, vecs[i].ordy, vecs[i].fl,
                  vecs[i].pc, vecs[i].op, vecs[i].ctrl);
            #1;
`ifndef SKID_BUF_EN
            check($sformatf("v%0d_in_ready", i), in_ready, vecs[i].rdy);
`endif
            cyc();
            check($sformatf("v%0d_out_valid", i), out_valid, vecs[i].ov);
            check($sformatf("v%0d_out_ctrl", i), out_ctrl, vecs[i].ectrl);
            check($sformatf("v%0d_stall_cnt", i), stall_cnt, vecs[i].cnt);
            if (vecs[i].ov) check($sformatf("v%0d_out_pc", i), out_pc, vecs[i].epc);
        end

        // counter saturation; flush keeps it, reset clears it
        drive(1, 1, 0, 32'h300, 14'h021, 6'h10);
        cyc();
        drive(0, 0, 0, 32'h0, 14'h0, 6'h00);
        repeat (20) cyc();
        check("sat_cnt", stall_cnt, 4'd15);
        check("sat_hold_pc", out_pc, 32'h300);
        repeat (3) cyc();
        check("sat_stay", stall_cnt, 4'd15);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        check("sat_flush_valid", out_valid, 1'b0);
        check("sat_flush_cnt", stall_cnt, 4'd15);
        cyc();
        check("sat_idle_cnt", stall_cnt, 4'd15);

        // reset with an instruction in flight
        drive(1, 1, 0, 32'h400, 14'h031, 6'h20);
        cyc();
        check("mid_loaded", out_valid, 1'b1);
        drive(1, 0, 0, 32'h404, 14'h032, 6'h3F);
        reset = 1'b1;
        cyc();
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_ctrl", out_ctrl, 6'h00);
        check("mid_rst_cnt", stall_cnt, 4'd0);
        check("mid_rst_pc", out_pc, 32'h0);
        reset = 1'b0;
        drive(0, 1, 0, 32'h0, 14'h0, 6'h00);
        cyc();

`ifdef SKID_BUF_EN
        drive(1, 0, 0, 32'h500, 14'h041, 6'h01);
        cyc();
        check("sk_rdy_a", in_ready, 1'b1);
        drive(1, 0, 0, 32'h504, 14'h042, 6'h02);
        cyc();
        check("sk_rdy_b", in_ready, 1'b0);
        check("sk_head_a", out_pc, 32'h500);
        drive(0, 1, 0, 32'h0, 14'h0, 6'h00);
        cyc();
        check("sk_out_b", out_pc, 32'h504);
        check("sk_out_b_ctrl", out_ctrl, 6'h02);
        check("sk_rdy_free", in_ready, 1'b1);
        cyc();
        check("sk_empty", out_valid, 1'b0);
        drive(1, 0, 0, 32'h600, 14'h051, 6'h04);
        cyc();
        drive(1, 0, 0, 32'h604, 14'h052, 6'h08);
        cyc();
        check("sk_full", in_ready, 1'b0);
        drive(0, 0, 1, 32'h0, 14'h0, 6'h00);
        cyc();
        flush = 1'b0;
        check("sk_fl_valid", out_valid, 1'b0);
        check("sk_fl_ctrl", out_ctrl, 6'h00);
        check("sk_fl_rdy", in_ready, 1'b1);
        out_ready = 1'b1;
        cyc();
        check("sk_fl_gone", out_valid, 1'b0);
`endif

        repeat (2) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
